// File: rtl/filter_fetch_ctrl_pkg.sv
// Shared types and helpers for the filter fetch controller.
package filter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FIN
  } fetch_state_t;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned WORD_SHIFT     = 2;

  // Lane 0 is the first byte in stream order, so a partial word keeps the low lanes.
  function automatic logic [3:0] tail_mask(input logic [1:0] tail);
    logic [3:0] m;
    case (tail)
      2'd1:    m = 4'b0001;
      2'd2:    m = 4'b0011;
      2'd3:    m = 4'b0111;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/filter_fetch_ctrl_if.sv
// Word stream between the fetch controller, the filter memory and the PE loader.
interface filter_fetch_ctrl_if #(
    parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0] mem_addr;
  logic              word_valid;
  logic              word_ready;
  logic [3:0]        byte_en;
  logic              last;

  modport master(output mem_addr, word_valid, byte_en, last, input word_ready);
  modport slave(input mem_addr, word_valid, byte_en, last, output word_ready);
endinterface

// File: rtl/filter_fetch_ctrl.sv
// Walks a filter region word by word and hands each word to the PE loader.
// Optional multi-pass replay is enabled with `define FILTER_REPLAY_EN.
module filter_fetch_ctrl
  import filter_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  filt_len,
`ifdef FILTER_REPLAY_EN
    input  logic [3:0]        replay_cnt,
`endif
    output logic              busy,
    output logic              done,
    filter_fetch_ctrl_if.master bus
);

  fetch_state_t      r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-2:0]  r_words;
  logic [1:0]        r_tail;
  logic              r_valid;
  logic              r_last;
  logic [3:0]        r_be;
  logic              r_busy;
  logic              r_done;
`ifdef FILTER_REPLAY_EN
  logic [ADDR_W-1:0] r_base;
  logic [LEN_W-2:0]  r_words_init;
  logic [3:0]        r_rep;
  logic [3:0]        w_nxt_rep;
`endif

  logic              w_hs;
  logic              w_pass_end;
  logic              w_final;
  logic [LEN_W:0]    w_len_ceil;
  logic [ADDR_W-1:0] w_nxt_addr;
  logic [LEN_W-2:0]  w_nxt_words;
  logic [1:0]        w_nxt_tail;
  logic              w_nxt_last;
  logic [3:0]        w_nxt_be;

  assign w_hs = r_valid & bus.word_ready;

  // Next-word address/count/flags, shared by the IDLE launch and STREAM advance paths.
  always_comb begin
    w_len_ceil  = {1'b0, filt_len} + (LEN_W + 1)'(BYTES_PER_WORD - 1);
    w_pass_end  = (r_words == (LEN_W - 1)'(1));
    w_final     = w_pass_end;
    w_nxt_addr  = r_addr + ADDR_W'(BYTES_PER_WORD);
    w_nxt_words = r_words - (LEN_W - 1)'(1);
    w_nxt_tail  = r_tail;
`ifdef FILTER_REPLAY_EN
    w_nxt_rep = r_rep;
    w_final   = w_pass_end && (r_rep == '0);
    if (w_pass_end && (r_rep != '0)) begin
      w_nxt_addr  = r_base;
      w_nxt_words = r_words_init;
      w_nxt_rep   = r_rep - 4'd1;
    end
`endif
    if (r_state == IDLE) begin
      w_nxt_addr  = base_addr & ~ADDR_W'(BYTES_PER_WORD - 1);
      w_nxt_words = (LEN_W - 1)'(w_len_ceil >> WORD_SHIFT);
      w_nxt_tail  = filt_len[1:0];
`ifdef FILTER_REPLAY_EN
      w_nxt_rep = replay_cnt;
`endif
    end
    w_nxt_last = (w_nxt_words == (LEN_W - 1)'(1));
`ifdef FILTER_REPLAY_EN
    w_nxt_last = w_nxt_last && (w_nxt_rep == '0);
`endif
    w_nxt_be = (w_nxt_words == (LEN_W - 1)'(1)) ? tail_mask(w_nxt_tail) : 4'b1111;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_words <= '0;
      r_tail  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_be    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef FILTER_REPLAY_EN
      r_base       <= '0;
      r_words_init <= '0;
      r_rep        <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_addr  <= w_nxt_addr;
            r_words <= w_nxt_words;
            r_tail  <= w_nxt_tail;
            r_busy  <= 1'b1;
`ifdef FILTER_REPLAY_EN
            r_base       <= w_nxt_addr;
            r_words_init <= w_nxt_words;
            r_rep        <= w_nxt_rep;
`endif
            if (filt_len != '0) begin
              r_state <= STREAM;
              r_valid <= 1'b1;
              r_last  <= w_nxt_last;
              r_be    <= w_nxt_be;
            end else begin
              r_state <= FIN;
            end
          end
        end
        STREAM: begin
          if (w_hs) begin
            r_addr  <= w_nxt_addr;
            r_words <= w_nxt_words;
`ifdef FILTER_REPLAY_EN
            r_rep <= w_nxt_rep;
`endif
            if (w_final) begin
              r_state <= FIN;
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_be    <= '0;
              r_done  <= 1'b1;
            end else begin
              r_last <= w_nxt_last;
              r_be   <= w_nxt_be;
            end
          end
        end
        FIN: begin
          // Entered with done already set after a stream; a zero-length fetch
          // spends one extra FIN cycle raising it.
          if (r_done) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
          end else begin
            r_done <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.mem_addr   = r_addr;
  assign bus.word_valid = r_valid;
  assign bus.byte_en    = r_be;
  assign bus.last       = r_last;
  assign busy           = r_busy;
  assign done           = r_done;

endmodule

// File: tb/tb_filter_fetch_ctrl.sv
// Scoreboard bench for filter_fetch_ctrl: stimulus pushes expected words/done, a monitor pops and compares.
module tb_filter_fetch_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [9:0] base_addr = '0;
  logic [9:0] filt_len = '0;
  logic       busy;
  logic       done;
`ifdef FILTER_REPLAY_EN
  logic [3:0] replay_cnt = '0;
`endif

  filter_fetch_ctrl_if #(.ADDR_W(10)) bus ();

  filter_fetch_ctrl #(
      .ADDR_W(10),
      .LEN_W (10)
  ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .base_addr(base_addr),
      .filt_len (filt_len),
`ifdef FILTER_REPLAY_EN
      .replay_cnt(replay_cnt),
`endif
      .busy     (busy),
      .done     (done),
      .bus      (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  addr;
    logic [3:0]  be;
    logic        last;
    int unsigned cyc;
  } exp_t;

  exp_t        wq[$];
  int unsigned dq[$];
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  exp_t        me;
  int unsigned md;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops an expectation for every handshake and every done pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.word_valid && bus.word_ready) begin
        checks++;
        if (wq.size() == 0) begin
          errors++;
          $display("FAIL word_unexpected: addr=%h be=%b last=%b cycle=%0d, required no transfer",
                   bus.mem_addr, bus.byte_en, bus.last, cyc);
        end else begin
          me = wq.pop_front();
          if (bus.mem_addr !== me.addr || bus.byte_en !== me.be || bus.last !== me.last || cyc != me.cyc) begin
            errors++;
            $display("FAIL word: got addr=%h be=%b last=%b cycle=%0d, required addr=%h be=%b last=%b cycle=%0d",
                     bus.mem_addr, bus.byte_en, bus.last, cyc, me.addr, me.be, me.last, me.cyc);
          end
        end
      end
      if (done) begin
        checks++;
        if (dq.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected: done at cycle=%0d, required none", cyc);
        end else begin
          md = dq.pop_front();
          if (cyc != md) begin
            errors++;
            $display("FAIL done_cycle: got cycle=%0d, required cycle=%0d", cyc, md);
          end
        end
      end
    end
  end

  task automatic push_w(input logic [9:0] a, input logic [3:0] be, input logic l, input int unsigned c);
    exp_t e;
    e.addr = a; e.be = be; e.last = l; e.cyc = c;
    wq.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  // Pulses start for one cycle; k is the cycle in which start was high.
  task automatic go(input logic [9:0] b, input logic [9:0] l, output int unsigned k);
    @(posedge clk); #1;
    k = cyc;
    base_addr = b;
    filt_len = l;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (!busy && wq.size() == 0 && dq.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got busy=%b words_pending=%0d done_pending=%0d, required all zero",
               name, busy, wq.size(), dq.size());
      wq.delete();
      dq.delete();
    end
  endtask

  initial begin
    int unsigned k;
    bus.word_ready = 1'b1;

    #2;
    chk("rst_valid", {31'd0, bus.word_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_addr", {22'd0, bus.mem_addr}, 32'd0);
    chk("rst_be", {28'd0, bus.byte_en}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Full words, plus a start pulsed mid-stream that must be ignored.
    go(10'h010, 10'd16, k);
    push_w(10'h010, 4'hF, 1'b0, k + 1);
    push_w(10'h014, 4'hF, 1'b0, k + 2);
    push_w(10'h018, 4'hF, 1'b0, k + 3);
    push_w(10'h01C, 4'hF, 1'b1, k + 4);
    dq.push_back(k + 5);
    chk("busy_stream", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    base_addr = 10'h200; filt_len = 10'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle("t1");

    // Partial tail word.
    go(10'h020, 10'd9, k);
    push_w(10'h020, 4'hF, 1'b0, k + 1);
    push_w(10'h024, 4'hF, 1'b0, k + 2);
    push_w(10'h028, 4'b0001, 1'b1, k + 3);
    dq.push_back(k + 4);
    wait_idle("t2");

    // Consumer stalls for 3 cycles on word 2.
    go(10'h040, 10'd12, k);
    push_w(10'h040, 4'hF, 1'b0, k + 1);
    push_w(10'h044, 4'hF, 1'b0, k + 5);
    push_w(10'h048, 4'hF, 1'b1, k + 6);
    dq.push_back(k + 7);
    @(posedge clk); #1;
    bus.word_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_valid", {31'd0, bus.word_valid}, 32'd1);
      chk("stall_addr", {22'd0, bus.mem_addr}, 32'h044);
      chk("stall_be", {28'd0, bus.byte_en}, 32'hF);
      chk("stall_last", {31'd0, bus.last}, 32'd0);
      @(posedge clk); #1;
    end
    bus.word_ready = 1'b1;
    wait_idle("t3");

    // Address wrap past the top of the 10-bit space.
    go(10'h3F8, 10'd16, k);
    push_w(10'h3F8, 4'hF, 1'b0, k + 1);
    push_w(10'h3FC, 4'hF, 1'b0, k + 2);
    push_w(10'h000, 4'hF, 1'b0, k + 3);
    push_w(10'h004, 4'hF, 1'b1, k + 4);
    dq.push_back(k + 5);
    wait_idle("t4");

    // Zero length: done 2 cycles after start; start during done is ignored, next cycle accepted.
    go(10'h000, 10'd0, k);
    dq.push_back(k + 2);
    @(posedge clk); #1;
    base_addr = 10'h080; filt_len = 10'd4; start = 1'b1;
    @(posedge clk); #1;
    base_addr = 10'h084; filt_len = 10'd3;
    push_w(10'h084, 4'b0111, 1'b1, k + 4);
    dq.push_back(k + 5);
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle("t5");

    // Non-aligned base has its low bits forced to zero.
    go(10'h103, 10'd5, k);
    push_w(10'h100, 4'hF, 1'b0, k + 1);
    push_w(10'h104, 4'b0001, 1'b1, k + 2);
    dq.push_back(k + 3);
    wait_idle("t6");

    // Reset mid-stream: outputs clear at once and no done follows.
    go(10'h200, 10'd16, k);
    push_w(10'h200, 4'hF, 1'b0, k + 1);
    push_w(10'h204, 4'hF, 1'b0, k + 2);
    @(posedge clk); #1;
    @(posedge clk); #1;
    #1 rst = 1'b1;
    #1;
    chk("rstmid_valid", {31'd0, bus.word_valid}, 32'd0);
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_addr", {22'd0, bus.mem_addr}, 32'd0);
    chk("rstmid_last", {31'd0, bus.last}, 32'd0);
    chk("rstmid_be", {28'd0, bus.byte_en}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rstmid_pending", wq.size(), 32'd0);

`ifdef FILTER_REPLAY_EN
    // Two extra passes of a two-word filter, single last and done.
    replay_cnt = 4'd2;
    go(10'h300, 10'd8, k);
    replay_cnt = 4'd0;
    push_w(10'h300, 4'hF, 1'b0, k + 1);
    push_w(10'h304, 4'hF, 1'b0, k + 2);
    push_w(10'h300, 4'hF, 1'b0, k + 3);
    push_w(10'h304, 4'hF, 1'b0, k + 4);
    push_w(10'h300, 4'hF, 1'b0, k + 5);
    push_w(10'h304, 4'hF, 1'b1, k + 6);
    dq.push_back(k + 7);
    wait_idle("t8");
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("end_words_pending", wq.size(), 32'd0);
    chk("end_done_pending", dq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, required completion");
    $fatal(1);
  end

endmodule
